aes_inv_cipher: RTL
===================

Name: aes_inv_cipher

Overview:
- Iterative AES-128 decryption core; the receive-side counterpart of aes_cipher, sharing its byte ordering so that ciphertext from aes_cipher round-trips through this block.
- Takes a 128-bit ciphertext and the same cipher key aes_cipher uses.
- Expands the key forward on the fly to reach round key 10, then runs the FIPS-197 inverse cipher one round per clock using an inverse key schedule.
- No round-key storage.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, other values unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- datain  input  128  ciphertext; [127:120] is state byte 0 (column-major, FIPS-197)
- key  input  128  cipher key, same ordering
- dataout  output  128  plaintext; registered, held until the next completion
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse, coincident with dataout update

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, done=0, dataout=0, internal state/round-key/counter registers =0.
- FSM states: IDLE, KEYEXP, ROUND.
- IDLE: on start=1, latch datain into st and key into rk; cnt<=1; go to KEYEXP; busy<=1. With start=0, stay.
- KEYEXP, 10 cycles, cnt 1..10: rk<=fwd_step(rk, Rcon[cnt]); cnt++.
  - On cnt==10 the result is round key 10.
  - Same edge: st<=st^rk10 (combinational next value); go to ROUND; r<=9.
- ROUND, 10 cycles, r=9..0:
  - prk = inv_step(rk, Rcon[r+1]), where w1'=w1^w0, w2'=w2^w1, w3'=w3^w2, w0'=w0^SubWord(RotWord(w3'))^Rcon[r+1].
  - t = InvSubBytes(InvShiftRows(st)) ^ prk.
  - st<=InvMixColumns(t) for r>=1; for r==0 skip InvMixColumns.
  - rk<=prk; r--.
  - At r==0: dataout<=t, done<=1, busy<=0, go to IDLE.
- Latency: start sampled at edge E gives done/dataout valid after edge E+20. Throughput is one block per 21 cycles, because start is re-sampled in IDLE only.
- start while busy=1: ignored, no queuing.
- datain/key may change freely after acceptance.
- done is cleared the cycle after it pulses.
- Reset mid-operation: aborts immediately to reset values; no done pulse.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- GF(2^8) polynomial 0x11b. InvMixColumns coefficients 0e,0b,0d,09.

Decomposition:
- Shared package aes_pkg:
  - FSM state encoding
  - Rcon table
  - xtime/gmul functions
  - forward S-box function (used by key schedule, shared with aes_cipher)
  - InvShiftRows index mapping
- One natural sub-module: aes_inv_sbox, a combinational 8-bit inverse S-box instantiated 16x in the data path.
- Key-step and InvMixColumns logic stays in the top as package functions.

Test Plan:
- FIPS-197 App. C.1: key=000102030405060708090a0b0c0d0e0f, datain=69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done exactly 20 cycles after acceptance edge, dataout=00112233445566778899aabbccddeeff.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, datain=3925841d02dc09fbdc118597196a0b32 -> dataout=3243f6a8885a308d313198a2e0370734; key schedule internal rk after KEYEXP = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Round-trip: datain=10, key=20 through aes_cipher, feed its dataout with key=20 -> dataout=128'd10. Also all-zero and all-ones key/data pairs.
- Busy handling: assert start again at cycles 5 and 15 and change datain/key mid-run -> result equals first block, single done pulse; a second start one cycle after done -> second correct result 20 cycles later.
- Reset mid-run: drop rst_n at cycle 12 asynchronously (between edges) -> busy/done/dataout=0 immediately, no done afterward; new start after release -> correct result.
- Back-to-back C.1 then B vectors with start held high continuously -> two done pulses 21 cycles apart, correct outputs each.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_pkg : shared AES definitions (FSM encoding, Rcon, GF(2^8), S-box)       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2
    } aes_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gmul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Source byte index for InvShiftRows: row r rotates right by r columns.
    function automatic int unsigned inv_shift_src(input int unsigned n);
        int unsigned row;
        int unsigned col;
        row = n % 4;
        col = n / 4;
        return row + 4 * ((col + 4 - row) % 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_inv_sbox : combinational AES inverse S-box (inverse affine + GF inverse)|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    logic [7:0] w_pre;

    assign w_pre  = {i_data[6:0], i_data[7]} ^ {i_data[4:0], i_data[7:5]} ^
                    {i_data[1:0], i_data[7:2]} ^ 8'h05;
    assign o_data = gf_inv(w_pre);

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_inv_cipher : iterative AES-128 decryption, one round per clock,         |
// |                  forward key expansion then on-the-fly inverse schedule.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] datain,
    input  logic [127:0] key,
    output logic [127:0] dataout,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] c_last_cnt  = 4'(NR);
    localparam logic [3:0] c_first_rnd = 4'(NR - 1);

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one forward step: recover w1..w3 first, then w0 from the recovered w3.
    function automatic logic [127:0] inv_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = rk[31:0]  ^ rk[63:32];
        n2 = rk[63:32] ^ rk[95:64];
        n1 = rk[95:64] ^ rk[127:96];
        n0 = rk[127:96] ^ sub_word({n3[23:0], n3[31:24]}) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {
                gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3),
                gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3),
                gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3),
                gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3)};
        end
        return r;
    endfunction

    aes_state_t   r_state;
    logic [127:0] r_st;
    logic [127:0] r_rk;
    logic [3:0]   r_cnt;
    logic [3:0]   r_rnd;

    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_rk_fwd;
    logic [127:0] w_prk;
    logic [127:0] w_t;
    logic [127:0] w_imc;

    for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sbox
        localparam int unsigned c_src = inv_shift_src(gi);
        assign w_isr[127-8*gi -: 8] = r_st[127-8*c_src -: 8];
        aes_inv_sbox u_inv_sbox (
            .i_data (w_isr[127-8*gi -: 8]),
            .o_data (w_isb[127-8*gi -: 8])
        );
    end

    assign w_rk_fwd = fwd_step(r_rk, rcon(r_cnt));
    assign w_prk    = inv_step(r_rk, rcon(r_rnd + 4'd1));
    assign w_t      = w_isb ^ w_prk;
    assign w_imc    = inv_mix_columns(w_t);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_st    <= '0;
            r_rk    <= '0;
            r_cnt   <= '0;
            r_rnd   <= '0;
            dataout <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_st    <= datain;
                        r_rk    <= key;
                        r_cnt   <= 4'd1;
                        busy    <= 1'b1;
                        r_state <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    r_rk  <= w_rk_fwd;
                    r_cnt <= r_cnt + 4'd1;
                    // Last expansion step also applies the initial AddRoundKey.
                    if (r_cnt == c_last_cnt) begin
                        r_st    <= r_st ^ w_rk_fwd;
                        r_rnd   <= c_first_rnd;
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_rk  <= w_prk;
                    r_rnd <= r_rnd - 4'd1;
                    if (r_rnd == 4'd0) begin
                        r_st    <= w_t;
                        dataout <= w_t;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_st <= w_imc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
